uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 169 ++++++++++++++++
 tb/tb_uart_rx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// AXI4-Stream UART receiver: 8N1-style frames on rxd, bit period = prescale*8 clk cycles.
// Optional UART_RX_MAJORITY_EN: each sample is the 2-of-3 majority of rx at counter 2, 1, 0.
module uart_rx #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   input  logic                  rxd,
   output logic                  busy,
   output logic                  overrun_error,
   output logic                  frame_error,
   input  logic [15:0]           prescale
);

   typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

   state_e                state_q, state_d;
   logic [18:0]           cnt_q, cnt_d;
   logic [15:0]           p_q, p_d;
   logic [3:0]            bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
   logic                  tvalid_q, tvalid_d;
   logic                  busy_q, busy_d;
   logic                  overrun_q, overrun_d;
   logic                  frame_q, frame_d;
   logic                  rx_meta_q, rx_sync_q;
   logic                  rx;
   logic                  sample;
   logic [15:0]           p_in;
   logic [18:0]           half_load;
   logic [18:0]           bit_load;

   assign rx = rx_sync_q;

`ifdef UART_RX_MAJORITY_EN
   // hist_q[1] is rx at counter==2, hist_q[0] at counter==1 when the counter reaches 0.
   logic [1:0] hist_q;

   always_ff @(posedge clk) begin
      if (rst) hist_q <= 2'b11;
      else     hist_q <= {hist_q[0], rx};
   end

   assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx) | (hist_q[0] & rx);
`else
   assign sample = rx;
`endif

   assign p_in      = (prescale == 16'd0) ? 16'd1 : prescale;
   assign half_load = {1'b0, p_in, 2'b00} - 19'd1;
   assign bit_load  = {p_q, 3'b000} - 19'd1;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      p_d       = p_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      tdata_d   = tdata_q;
      tvalid_d  = tvalid_q;
      busy_d    = busy_q;
      overrun_d = 1'b0;
      frame_d   = 1'b0;

      if (tvalid_q && m_axis_tready) tvalid_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            busy_d = 1'b0;
            if (!rx) begin
               p_d     = p_in;
               cnt_d   = half_load;
               busy_d  = 1'b1;
               state_d = StStart;
            end
         end
         StStart: begin
            cnt_d = cnt_q - 19'd1;
            if (cnt_q == 19'd0) begin
               if (!sample) begin
                  cnt_d     = bit_load;
                  bit_cnt_d = 4'(DATA_WIDTH);
                  state_d   = StData;
               end else begin
                  busy_d  = 1'b0;
                  state_d = StIdle;
               end
            end
         end
         StData: begin
            cnt_d = cnt_q - 19'd1;
            if (cnt_q == 19'd0) begin
               shift_d                 = shift_q >> 1;
               shift_d[DATA_WIDTH-1]   = sample;
               cnt_d                   = bit_load;
               bit_cnt_d               = bit_cnt_q - 4'd1;
               if (bit_cnt_q == 4'd1) state_d = StStop;
            end
         end
         StStop: begin
            cnt_d = cnt_q - 19'd1;
            if (cnt_q == 19'd0) begin
               if (sample) begin
                  tdata_d   = shift_q;
                  tvalid_d  = 1'b1;
                  overrun_d = tvalid_q & ~m_axis_tready;
                  busy_d    = 1'b0;
                  state_d   = StIdle;
               end else begin
                  // Hold off until the line returns high so a break reports only once.
                  frame_d = 1'b1;
                  state_d = StBreak;
               end
            end
         end
         StBreak: begin
            if (rx) begin
               busy_d  = 1'b0;
               state_d = StIdle;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         p_q       <= 16'd1;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         tdata_q   <= '0;
         tvalid_q  <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         frame_q   <= 1'b0;
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         p_q       <= p_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         tdata_q   <= tdata_d;
         tvalid_q  <= tvalid_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
         frame_q   <= frame_d;
         rx_meta_q <= rxd;
         rx_sync_q <= rx_meta_q;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign busy          = busy_q;
   assign overrun_error = overrun_q;
   assign frame_error   = frame_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of clean frames plus hand sequences for
// glitches, break, overrun, mid-frame reset and the sampling-window glitch.
module tb_uart_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        rxd;
   logic        busy;
   logic        overrun_error;
   logic        frame_error;
   logic [15:0] prescale;

   uart_rx #(.DATA_WIDTH(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .rxd           (rxd),
      .busy          (busy),
      .overrun_error (overrun_error),
      .frame_error   (frame_error),
      .prescale      (prescale)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Running event totals; tests compare deltas against snapshots.
   int         acc_cnt  = 0;
   int         ovr_cnt  = 0;
   int         fe_cnt   = 0;
   int         busy_cyc = 0;
   logic [7:0] last_word = 8'h00;

   always @(negedge clk) begin
      if (!rst) begin
         if (m_axis_tvalid && m_axis_tready) begin
            acc_cnt   <= acc_cnt + 1;
            last_word <= m_axis_tdata;
         end
         if (overrun_error) ovr_cnt <= ovr_cnt + 1;
         if (frame_error) fe_cnt <= fe_cnt + 1;
         if (busy) busy_cyc <= busy_cyc + 1;
      end
   end

   int b_acc, b_ovr, b_fe, b_busy;

   task automatic snap();
      b_acc  = acc_cnt;
      b_ovr  = ovr_cnt;
      b_fe   = fe_cnt;
      b_busy = busy_cyc;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drives one frame; c counts clk cycles from the start-bit edge.
   // glitch_c inverts rxd for that one cycle; abort_c stops driving at that cycle.
   task automatic send_frame(input logic [7:0] d, input int p, input logic stop_v,
                             input int glitch_c, input int abort_c);
      int   bp;
      int   bi;
      logic bitv;
      bp = 8 * ((p == 0) ? 1 : p);
      for (int c = 0; c < 10 * bp; c++) begin
         if (c == abort_c) return;
         @(posedge clk);
         #1;
         bi = c / bp;
         if (bi == 0)      bitv = 1'b0;
         else if (bi == 9) bitv = stop_v;
         else              bitv = d[bi-1];
         if (c == glitch_c) bitv = ~bitv;
         rxd = bitv;
      end
   endtask

   typedef struct {
      logic [7:0] data;
      int         p;
      logic [7:0] exp_word;
      int         exp_busy;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] glitch_exp;

      vecs[0] = '{data: 8'hA5, p: 1, exp_word: 8'hA5, exp_busy: 76};
      vecs[1] = '{data: 8'h00, p: 1, exp_word: 8'h00, exp_busy: 76};
      vecs[2] = '{data: 8'hFF, p: 1, exp_word: 8'hFF, exp_busy: 76};
      vecs[3] = '{data: 8'h3C, p: 2, exp_word: 8'h3C, exp_busy: 152};
      vecs[4] = '{data: 8'h81, p: 3, exp_word: 8'h81, exp_busy: 228};
      vecs[5] = '{data: 8'h55, p: 0, exp_word: 8'h55, exp_busy: 76};

      rst           = 1'b1;
      rxd           = 1'b1;
      m_axis_tready = 1'b1;
      prescale      = 16'd1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_tdata", int'(m_axis_tdata), 0);
      chk("reset_tvalid", int'(m_axis_tvalid), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_ovr", int'(overrun_error), 0);
      chk("reset_fe", int'(frame_error), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) @(posedge clk);

      // Clean frames.
      for (int i = 0; i < 6; i++) begin
         prescale = 16'(vecs[i].p);
         snap();
         send_frame(vecs[i].data, vecs[i].p, 1'b1, -1, -1);
         repeat (3) @(posedge clk);
         #1;
         chk("vec_word", int'(last_word), int'(vecs[i].exp_word));
         chk("vec_accepts", acc_cnt - b_acc, 1);
         chk("vec_fe", fe_cnt - b_fe, 0);
         chk("vec_ovr", ovr_cnt - b_ovr, 0);
         chk("vec_busy_cycles", busy_cyc - b_busy, vecs[i].exp_busy);
      end

      // Two-cycle low glitch: rejected at the start sample point.
      prescale = 16'd1;
      snap();
      @(posedge clk); #1; rxd = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1; rxd = 1'b1;
      repeat (5) @(negedge clk);
      chk("glitch_busy_high", int'(busy), 1);
      @(negedge clk);
      chk("glitch_busy_low", int'(busy), 0);
      repeat (10) @(posedge clk);
      #1;
      chk("glitch_accepts", acc_cnt - b_acc, 0);
      chk("glitch_fe", fe_cnt - b_fe, 0);
      chk("glitch_busy_cycles", busy_cyc - b_busy, 4);

      // Bad stop bit followed by a held break.
      prescale = 16'd2;
      snap();
      send_frame(8'h3C, 2, 1'b0, -1, -1);
      repeat (48) @(posedge clk);
      #1;
      chk("break_busy_held", int'(busy), 1);
      rxd = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("break_busy_low", int'(busy), 0);
      chk("break_fe_once", fe_cnt - b_fe, 1);
      chk("break_accepts", acc_cnt - b_acc, 0);
      chk("break_tvalid", int'(m_axis_tvalid), 0);

      // Overrun with a stalled consumer.
      prescale      = 16'd1;
      m_axis_tready = 1'b0;
      snap();
      send_frame(8'h11, 1, 1'b1, -1, -1);
      send_frame(8'h22, 1, 1'b1, -1, -1);
      repeat (3) @(posedge clk);
      #1;
      chk("ovr_tvalid", int'(m_axis_tvalid), 1);
      chk("ovr_tdata", int'(m_axis_tdata), 8'h22);
      chk("ovr_pulses", ovr_cnt - b_ovr, 1);
      m_axis_tready = 1'b1;
      @(posedge clk);
      #1;
      chk("ovr_tvalid_cleared", int'(m_axis_tvalid), 0);
      chk("ovr_accepted_word", int'(last_word), 8'h22);
      chk("ovr_accepts", acc_cnt - b_acc, 1);

      // Reset in the middle of data bit 4, then a clean frame.
      send_frame(8'h5A, 1, 1'b1, -1, 44);
      @(posedge clk); #1; rst = 1'b1; rxd = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      chk("rst_mid_tvalid", int'(m_axis_tvalid), 0);
      chk("rst_mid_busy", int'(busy), 0);
      repeat (10) @(posedge clk);
      snap();
      send_frame(8'h81, 1, 1'b1, -1, -1);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_after_word", int'(last_word), 8'h81);
      chk("rst_after_accepts", acc_cnt - b_acc, 1);

      // One-cycle high spike exactly at the bit-3 sample point.
`ifdef UART_RX_MAJORITY_EN
      glitch_exp = 8'h00;
`else
      glitch_exp = 8'h08;
`endif
      snap();
      send_frame(8'h00, 1, 1'b1, 36, -1);
      repeat (3) @(posedge clk);
      #1;
      chk("spike_word", int'(last_word), int'(glitch_exp));
      chk("spike_accepts", acc_cnt - b_acc, 1);
      chk("spike_fe", fe_cnt - b_fe, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
